// File: rtl/audio_clkgen_pkg.sv
// Shared constants, rate encoding, FSM states and divisor lookup for the
// WM8731 slave-mode clock generator.
package audio_clkgen_pkg;

  localparam int HALF_48K    = 4;   // 24.576 MHz / 8  = 3.072 MHz BCLK
  localparam int HALF_32K    = 6;
  localparam int HALF_8K     = 24;
  localparam int FRAME_BCLKS = 64;  // 32 left + 32 right, power of two
  localparam int BIT_W       = $clog2(FRAME_BCLKS);
  localparam int CNT_W       = 5;   // wide enough for the largest half-period

  localparam logic [1:0] RATE_48K = 2'd0;
  localparam logic [1:0] RATE_32K = 2'd1;
  localparam logic [1:0] RATE_8K  = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Clk cycles per BCLK half-period for a (normalised) rate code.
  function automatic logic [CNT_W-1:0] half_period(input logic [1:0] rate);
    case (rate)
      RATE_32K: half_period = CNT_W'(HALF_32K);
      RATE_8K:  half_period = CNT_W'(HALF_8K);
      default:  half_period = CNT_W'(HALF_48K);
    endcase
  endfunction

  // The reserved code runs as 48k and is reported as such.
  function automatic logic [1:0] rate_norm(input logic [1:0] rate);
    rate_norm = (rate == 2'd3) ? RATE_48K : rate;
  endfunction

endpackage

// File: rtl/audio_clkgen_div.sv
// Loadable half-period divider: toggles its output every 'half' clks while
// running and flags the clk on which the output falls.
module audio_clkgen_div
  import audio_clkgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] half,
  output logic             tgl,
  output logic             fall
);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc   = run && (cnt == half - 1'b1);
  assign fall = tc && tgl;

  // Count to terminal, then toggle; clear parks the output low at phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tgl <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      tgl <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      tgl <= ~tgl;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_codec_clkgen.sv
// WM8731 slave-mode clock generator: XCK, BCLK, shared LRCK, frame strobe,
// bit index and frame-aligned start/stop and rate switching.
module audio_codec_clkgen
  import audio_clkgen_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       rate_sel,
  output logic             xck,
  output logic             bclk,
  output logic             lrck,
  output logic             frame_start,
  output logic [BIT_W-1:0] bit_index,
  output logic             active,
  output logic [1:0]       rate_cur
);

  state_t           state, state_nxt;
  logic             start, fall, wrap, to_idle;
  logic [BIT_W-1:0] bit_nxt;

  assign bit_nxt = bit_index + 1'b1;
  assign wrap    = fall && (bit_index == BIT_W'(FRAME_BCLKS - 1));
  assign to_idle = (state_nxt == IDLE);

  // Codec MCLK runs whenever out of reset so I2C setup can proceed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) xck <= 1'b0;
    else       xck <= ~xck;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: stop requests only take effect on a frame boundary.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN:   if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)    state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  audio_clkgen_div u_div (
    .clk   (clk),
    .rst   (reset),
    .run   (state != IDLE),
    .clear (state == IDLE || to_idle),
    .half  (half_period(rate_cur)),
    .tgl   (bclk),
    .fall  (fall)
  );

  // Bit counter, LRCK and rate latch advance on BCLK falling edges only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      active      <= 1'b0;
      bit_index   <= '0;
      lrck        <= 1'b0;
      rate_cur    <= RATE_48K;
    end else begin
      frame_start <= start || (wrap && !to_idle);
      active      <= !to_idle;
      if (start) begin
        rate_cur  <= rate_norm(rate_sel);
        bit_index <= '0;
        lrck      <= 1'b0;
      end else if (to_idle) begin
        bit_index <= '0;
        lrck      <= 1'b0;
      end else if (fall) begin
        bit_index <= bit_nxt;
        lrck      <= bit_nxt[BIT_W-1];
        if (wrap) rate_cur <= rate_norm(rate_sel);
      end
    end
  end

endmodule
